// File: rtl/wb_demux_pkg.sv
// wb_demux shared definitions: writeback select codes, FSM state
// codes, flag bit positions and small select-decoding helpers.
package wb_demux_pkg;

    typedef enum logic [2:0] {
        WB_REG_FLG = 3'b000,
        WB_REG     = 3'b001,
        WB_FLG     = 3'b010,
        WB_PC      = 3'b011,
        WB_ST      = 3'b100,
        WB_LD      = 3'b101,
        WB_NOP     = 3'b110
    } wb_sel_e;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMMIT  = 2'd1;
    localparam logic [1:0] S_MEM_REQ = 2'd2;
    localparam logic [1:0] S_MEM_WB  = 2'd3;

    // alu_flags / sr_flags layout {S,V,Z,C}
    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_V = 2;
    localparam int FLG_S = 3;

    function automatic logic is_mem(input logic [2:0] sel);
        return (sel == WB_ST) || (sel == WB_LD);
    endfunction

    // 000 writes the register file in both builds; without the flag
    // path it simply degenerates to a plain register write.
    function automatic logic writes_rf(input logic [2:0] sel);
        return (sel == WB_REG_FLG) || (sel == WB_REG);
    endfunction

    function automatic logic writes_sr(input logic [2:0] sel);
        return (sel == WB_REG_FLG) || (sel == WB_FLG);
    endfunction

endpackage

// File: rtl/wb_demux_if.sv
// wb_demux bus bundle: controller request side, register/PC/flag
// writeback ports and the memory handshake. slave = demux side.
interface wb_demux_if #(
    parameter int DW = 16,
    parameter int RA = 3
);
    logic          start;
    logic [2:0]    wb_sel;
    logic [DW-1:0] alu_out;
    logic [3:0]    alu_flags;
    logic [RA-1:0] dst_idx;
    logic [DW-1:0] st_data;
    logic          rf_we;
    logic [RA-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          pc_load;
    logic [DW-1:0] pc_next;
    logic          sr_we;
    logic [3:0]    sr_flags;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;

    modport slave (
        input  start, wb_sel, alu_out, alu_flags, dst_idx, st_data,
        input  mem_ack, mem_rdata,
        output rf_we, rf_waddr, rf_wdata, pc_load, pc_next,
        output sr_we, sr_flags, mem_req, mem_we, mem_addr, mem_wdata,
        output busy, done
    );

    modport master (
        output start, wb_sel, alu_out, alu_flags, dst_idx, st_data,
        output mem_ack, mem_rdata,
        input  rf_we, rf_waddr, rf_wdata, pc_load, pc_next,
        input  sr_we, sr_flags, mem_req, mem_we, mem_addr, mem_wdata,
        input  busy, done
    );

endinterface

// File: rtl/wb_demux_mem_if.sv
// wb_mem_if: memory request holder. launch loads addr/data/dir and
// raises req; req, we, addr, wdata stay put until ack.
// Ports: launch_* (load), ack/ack_rdata (memory), req/we/addr/wdata
// (to memory), rdata (captured read data), fire (ack accepted).
module wb_mem_if #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          launch,
    input  logic          launch_we,
    input  logic [DW-1:0] launch_addr,
    input  logic [DW-1:0] launch_wdata,
    input  logic          ack,
    input  logic [DW-1:0] ack_rdata,
    output logic          req,
    output logic          we,
    output logic [DW-1:0] addr,
    output logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          fire
);

    // ack with no request outstanding is dropped here
    assign fire = req && ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req   <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            rdata <= '0;
        end else if (launch) begin
            req   <= 1'b1;
            we    <= launch_we;
            addr  <= launch_addr;
            wdata <= launch_wdata;
        end else if (fire) begin
            req <= 1'b0;
            we  <= 1'b0;
            if (!we) begin
                rdata <= ack_rdata;
            end
        end
    end

endmodule

// File: rtl/wb_demux.sv
// wb_demux: latches one ALU result per op and steers it to the
// register file, PC, flag register or a memory read/write.
// Ports: clk, rst_n (async, active low), bus (wb_demux_if.slave).
// Macro WB_DEMUX_FLAGS_EN keeps the flag register path; without it
// sr_we/sr_flags are tied 0, 000 acts as 001 and 010 as a no-op.
module wb_demux
    import wb_demux_pkg::*;
#(
    parameter int DW = 16,
    parameter int RA = 3
) (
    input logic     clk,
    input logic     rst_n,
    wb_demux_if.slave bus
);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [2:0]    sel_q;
    logic [DW-1:0] res_q;
    logic [RA-1:0] dst_q;
    logic          accept;
    logic          in_commit;
    logic          in_memwb;
    logic          mem_fire;
    logic          mem_we_q;
    logic [DW-1:0] rdata_q;

    assign accept    = (state == S_IDLE) && bus.start;
    assign in_commit = (state == S_COMMIT);
    assign in_memwb  = (state == S_MEM_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sel_q <= '0;
            res_q <= '0;
            dst_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sel_q <= bus.wb_sel;
                res_q <= bus.alu_out;
                dst_q <= bus.dst_idx;
            end
        end
    end

    // a store completes through COMMIT: its select drives no strobe
    // there, so that cycle only pulses done
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = is_mem(bus.wb_sel) ? S_MEM_REQ : S_COMMIT;
                end
            end
            S_MEM_REQ: begin
                if (mem_fire) begin
                    state_nx = mem_we_q ? S_COMMIT : S_MEM_WB;
                end
            end
            S_COMMIT: state_nx = S_IDLE;
            S_MEM_WB: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    wb_mem_if #(.DW(DW)) u_mem (
        .clk          (clk),
        .rst_n        (rst_n),
        .launch       (accept && is_mem(bus.wb_sel)),
        .launch_we    (bus.wb_sel == WB_ST),
        .launch_addr  (bus.alu_out),
        .launch_wdata (bus.st_data),
        .ack          (bus.mem_ack),
        .ack_rdata    (bus.mem_rdata),
        .req          (bus.mem_req),
        .we           (mem_we_q),
        .addr         (bus.mem_addr),
        .wdata        (bus.mem_wdata),
        .rdata        (rdata_q),
        .fire         (mem_fire)
    );

    assign bus.mem_we = mem_we_q;

    assign bus.rf_we    = (in_commit && writes_rf(sel_q)) || in_memwb;
    assign bus.rf_waddr = dst_q;
    assign bus.rf_wdata = in_memwb ? rdata_q : res_q;
    assign bus.pc_load  = in_commit && (sel_q == WB_PC);
    assign bus.pc_next  = res_q;
    assign bus.done     = in_commit || in_memwb;
    assign bus.busy     = (state != S_IDLE);

`ifdef WB_DEMUX_FLAGS_EN
    logic [3:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (accept) begin
            flags_q <= bus.alu_flags;
        end
    end

    assign bus.sr_we    = in_commit && writes_sr(sel_q);
    assign bus.sr_flags = flags_q;
`else
    logic unused_flags;
    assign unused_flags = ^bus.alu_flags;
    assign bus.sr_we    = 1'b0;
    assign bus.sr_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_wb_demux.sv
// wb_demux bench: directed test-plan ops, randomized op stream with
// random memory wait states, checked against a writeback-effect model.
module tb_wb_demux;
    import wb_demux_pkg::*;

`ifdef WB_DEMUX_FLAGS_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail = 0;

    wb_demux_if #(.DW(16), .RA(3)) bus ();

    wb_demux #(.DW(16), .RA(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, done=%0b busy=%0b",
                 bus.done, bus.busy);
        $fatal(1, "watchdog");
    end

    task automatic scramble();
        bus.wb_sel    = 3'($urandom);
        bus.alu_out   = 16'($urandom);
        bus.alu_flags = 4'($urandom);
        bus.dst_idx   = 3'($urandom);
        bus.st_data   = 16'($urandom);
        bus.mem_rdata = 16'($urandom);
    endtask

    // Called at a negedge with the DUT idle. Drives start right away,
    // walks the op and returns at the negedge of the cycle after done.
    task automatic exec_op(input logic [2:0] sel, input logic [15:0] alu,
                           input logic [3:0] flg, input logic [2:0] dst,
                           input logic [15:0] st, input int wt,
                           input logic [15:0] rd, input bit poke);
        bit         is_st, is_ld, e_rf, e_pc, e_sr;
        logic [15:0] e_wd;
        logic [5:0] obs6, exp6;
        int         held;
        is_st = (sel == 3'd4);
        is_ld = (sel == 3'd5);
        e_rf  = (sel == 3'd0) || (sel == 3'd1) || is_ld;
        e_pc  = (sel == 3'd3);
        e_sr  = FE && ((sel == 3'd0) || (sel == 3'd2));
        e_wd  = is_ld ? rd : alu;
        bus.start     = 1'b1;
        bus.wb_sel    = sel;
        bus.alu_out   = alu;
        bus.alu_flags = flg;
        bus.dst_idx   = dst;
        bus.st_data   = st;
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
        if (is_st || is_ld) begin
            held = 0;
            for (int i = 0; i <= wt; i++) begin
                n_tests++;
                obs6 = {bus.mem_req, bus.mem_we, bus.done, bus.rf_we,
                        bus.busy, bus.pc_load};
                exp6 = {1'b1, is_st, 1'b0, 1'b0, 1'b1, 1'b0};
                if (obs6 !== exp6 || bus.mem_addr !== alu) begin
                    n_fail++;
                    $display("FAIL mem_wait sel=%0d i=%0d got req/we/done/rfwe/busy/pc=%b addr=%h want %b addr=%h",
                             sel, i, obs6, bus.mem_addr, exp6, alu);
                end
                if (is_st) begin
                    n_tests++;
                    if (bus.mem_wdata !== st) begin
                        n_fail++;
                        $display("FAIL mem_wdata got %h want %h",
                                 bus.mem_wdata, st);
                    end
                end
                if (bus.mem_req === 1'b1) held++;
                if (poke && i == 0) begin
                    bus.start  = 1'b1;
                    bus.wb_sel = 3'd1;
                end
                if (i == wt) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rd;
                end
                @(negedge clk);
                bus.start   = 1'b0;
                bus.mem_ack = 1'b0;
                scramble();
            end
            n_tests++;
            if (held != wt + 1) begin
                n_fail++;
                $display("FAIL mem_req_len got %0d want %0d", held, wt + 1);
            end
        end
        n_tests++;
        obs6 = {bus.done, bus.busy, bus.mem_req, bus.rf_we,
                bus.pc_load, bus.sr_we};
        exp6 = {1'b1, 1'b1, 1'b0, e_rf, e_pc, e_sr};
        if (obs6 !== exp6) begin
            n_fail++;
            $display("FAIL done_cycle sel=%0d got done/busy/req/rf/pc/sr=%b want %b",
                     sel, obs6, exp6);
        end
        if (e_rf) begin
            n_tests++;
            if (bus.rf_waddr !== dst || bus.rf_wdata !== e_wd) begin
                n_fail++;
                $display("FAIL rf_data sel=%0d got %0d/%h want %0d/%h",
                         sel, bus.rf_waddr, bus.rf_wdata, dst, e_wd);
            end
        end
        if (e_pc) begin
            n_tests++;
            if (bus.pc_next !== alu) begin
                n_fail++;
                $display("FAIL pc_next got %h want %h", bus.pc_next, alu);
            end
        end
        if (e_sr || !FE) begin
            n_tests++;
            if (bus.sr_flags !== (FE ? flg : 4'b0000)) begin
                n_fail++;
                $display("FAIL sr_flags got %b want %b", bus.sr_flags,
                         FE ? flg : 4'b0000);
            end
        end
        @(negedge clk);
        n_tests++;
        obs6 = {bus.done, bus.busy, bus.mem_req, bus.rf_we,
                bus.pc_load, bus.sr_we};
        if (obs6 !== 6'b0) begin
            n_fail++;
            $display("FAIL after_done sel=%0d got %b want 000000",
                     sel, obs6);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.mem_ack = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.rf_we, bus.pc_load, bus.sr_we, bus.mem_req, bus.mem_we,
             bus.busy, bus.done} !== 7'b0 ||
            {bus.rf_waddr, bus.rf_wdata, bus.pc_next, bus.sr_flags,
             bus.mem_addr, bus.mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_state strobes=%b pc=%h rf=%h addr=%h want 0",
                     {bus.rf_we, bus.pc_load, bus.sr_we, bus.mem_req,
                      bus.mem_we, bus.busy, bus.done},
                     bus.pc_next, bus.rf_wdata, bus.mem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        exec_op(3'd0, 16'h1234, 4'b0100, 3'd5, 16'h0, 0, 16'h0, 1'b0);
        exec_op(3'd3, 16'h00F0, 4'b1111, 3'd1, 16'h0, 0, 16'h0, 1'b0);
        exec_op(3'd4, 16'h8000, 4'b0000, 3'd0, 16'hBEEF, 2, 16'h0, 1'b0);
        exec_op(3'd5, 16'h0010, 4'b0000, 3'd2, 16'h0, 0, 16'hCAFE, 1'b0);
        exec_op(3'd2, 16'h5555, 4'b1001, 3'd3, 16'h0, 0, 16'h0, 1'b0);
        exec_op(3'd6, 16'hAAAA, 4'b0110, 3'd4, 16'h0, 0, 16'h0, 1'b0);
        exec_op(3'd7, 16'h0F0F, 4'b0011, 3'd6, 16'h0, 0, 16'h0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            exec_op(3'($urandom), 16'($urandom), 4'($urandom),
                    3'($urandom), 16'($urandom), int'($urandom_range(0, 4)),
                    16'($urandom), 1'b0);
        end
    endtask

    task automatic test_busy_start();
        exec_op(3'd4, 16'h1357, 4'b0, 3'd0, 16'h2468, 3, 16'h0, 1'b1);
        exec_op(3'd5, 16'h0042, 4'b0, 3'd7, 16'h0, 0, 16'h9ABC, 1'b1);
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL extra_done got done=%b busy=%b want 0 0",
                         bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_stray_ack();
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_tests++;
        if ({bus.done, bus.busy, bus.mem_req, bus.rf_we} !== 4'b0) begin
            n_fail++;
            $display("FAIL stray_ack got done/busy/req/rf=%b want 0000",
                     {bus.done, bus.busy, bus.mem_req, bus.rf_we});
        end
    endtask

    task automatic test_reset_mid();
        bus.start   = 1'b1;
        bus.wb_sel  = 3'd4;
        bus.alu_out = 16'h7777;
        bus.st_data = 16'h1111;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_req got %b want 1", bus.mem_req);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.mem_req, bus.busy, bus.done} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_mid got req/busy/done=%b want 000",
                     {bus.mem_req, bus.busy, bus.done});
        end
        @(negedge clk);
        rst_n       = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        repeat (3) begin
            n_tests++;
            if ({bus.done, bus.busy, bus.rf_we, bus.mem_req} !== 4'b0) begin
                n_fail++;
                $display("FAIL post_reset got done/busy/rf/req=%b want 0000",
                         {bus.done, bus.busy, bus.rf_we, bus.mem_req});
            end
            @(negedge clk);
        end
        exec_op(3'd1, 16'h4321, 4'b0, 3'd3, 16'h0, 0, 16'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_start();
        test_stray_ack();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
